// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared types and constants for the MEM-stage data memory controller
//
// Contents:
//   MA_CNT_W    width of the latency down-counter (covers WAIT_CYCLES up to 15)
//   ma_state_t  controller FSM state encoding
package dmem_access_ctrl_pkg;

  localparam int MA_CNT_W = 4;

  typedef enum logic [1:0] {
    MA_IDLE    = 2'd0,
    MA_RD_BUSY = 2'd1,
    MA_WR_BUSY = 2'd2,
    MA_RD_DONE = 2'd3
  } ma_state_t;

endpackage

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store sequencer for a fixed-latency sync data memory
//
// Loads stall the pipeline until data returns; stores are posted and drain in the background.
// At most one memory op is outstanding, so a memory op behind a draining store waits for it.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   mem_read      load request (level, held while stall=1)
//   mem_write     store request (level)
//   addr, wdata   word address and store data from the pipeline
//   stall         freeze PC and pipeline registers
//   rdata         registered load result, held until the next load completes
//   rdata_valid   one-cycle pulse when rdata carries the current load's data
//   err           sticky: mem_read and mem_write were requested together
//   mem_en        memory access strobe, one cycle per op
//   mem_we        write select, valid with mem_en
//   mem_addr      memory word address
//   mem_wdata     memory write data
//   mem_rdata     memory read data, valid WAIT_CYCLES cycles after the issue edge
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter is loaded at issue; the busy state ends on the cycle it reads zero,
  // which is WAIT_CYCLES cycles after the issue edge.
  localparam logic [MA_CNT_W-1:0] CNT_LOAD = MA_CNT_W'(WAIT_CYCLES - 1);

  ma_state_t             state, state_next;
  logic [MA_CNT_W-1:0]   cnt, cnt_next;
  logic                  capture;
  logic                  err_set;
  logic                  stall_c, en_c, we_c, rv_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MA_IDLE;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) rdata <= mem_rdata;
      if (err_set) err   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    err_set    = 1'b0;
    stall_c    = 1'b0;
    en_c       = 1'b0;
    we_c       = 1'b0;
    rv_c       = 1'b0;
    case (state)
      MA_IDLE: begin
        // A simultaneous read+write request resolves to the write.
        if (mem_write) begin
          en_c       = 1'b1;
          we_c       = 1'b1;
          err_set    = mem_read;
          cnt_next   = CNT_LOAD;
          state_next = MA_WR_BUSY;
        end else if (mem_read) begin
          en_c       = 1'b1;
          stall_c    = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = MA_RD_BUSY;
        end
      end
      MA_RD_BUSY: begin
        stall_c = 1'b1;
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = MA_RD_DONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      MA_RD_DONE: begin
        // mem_read is still high here for the same load; do not reissue.
        rv_c       = 1'b1;
        state_next = MA_IDLE;
      end
      MA_WR_BUSY: begin
        // Only a following memory op has to wait for the posted store.
        stall_c = mem_read | mem_write;
        if (cnt == '0) begin
          state_next = MA_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = MA_IDLE;
    endcase
  end

  // Control outputs drop the moment reset asserts, even while the state
  // register is being cleared and inputs still request an access.
  assign stall       = stall_c & rst_n;
  assign mem_en      = en_c & rst_n;
  assign mem_we      = we_c & rst_n;
  assign rdata_valid = rv_c & rst_n;
  assign mem_addr    = addr;
  assign mem_wdata   = wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl with a behavioural sync RAM
module tb_dmem_access_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          stall;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem_model: writes land at the issue edge; read data walks a W-deep pipe
  // and is only correct for exactly one cycle, so wrong capture timing shows.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] pipe [W];
  assign mem_rdata = pipe[W-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 16'hDEAD;
    for (int i = 1; i < W; i++) pipe[i] <= pipe[i-1];
  end

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] rd_q [$];
  logic [24:0]   op_q [$];
  logic [DW-1:0] rd_e;
  logic [24:0]   op_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected load data and expected memory ops as the DUT presents them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdata_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rdata_valid: got rdata %0h expected no pulse", rdata);
        end else begin
          rd_e = rd_q.pop_front();
          checks--;
          chk("load_data", {16'h0, rdata}, {16'h0, rd_e});
        end
      end
      if (mem_en) begin
        checks++;
        if (op_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_mem_en: got we=%0b addr=%0h expected no access", mem_we, mem_addr);
        end else begin
          op_e = op_q.pop_front();
          checks--;
          if (op_e[24])
            chk("mem_write_op", {7'h0, mem_we, mem_addr, mem_wdata}, {7'h0, op_e});
          else
            chk("mem_read_op", {23'h0, mem_we, mem_addr}, {23'h0, op_e[24:16]});
        end
      end
    end
  end

  // One pipeline instruction: held until a cycle with stall=0, then advances.
  task automatic instr(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int exp_stall, input string name);
    int  n;
    bit  done;
    logic s;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    n = 0; done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      s = stall;
      if (s) n++;
      else begin
        done = 1;
        if (rd && !wr) chk({name, "_rv_on_release"}, {31'h0, rdata_valid}, 32'h1);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got stall stuck high expected release within 50 cycles", name);
    end else begin
      chk({name, "_stall_cycles"}, n, exp_stall);
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic lw(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int exp_stall);
    rd_q.push_back(exp);
    op_q.push_back({1'b0, a, 16'h0});
    instr(1'b1, 1'b0, a, 16'h0, exp_stall, "lw");
  endtask

  task automatic sw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_q.push_back({1'b1, a, d});
    instr(1'b0, 1'b1, a, d, 0, "sw");
  endtask

  task automatic alu();
    instr(1'b0, 1'b0, 8'h00, 16'h0, 0, "alu");
  endtask

  int rv_seen, stall_seen;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7);
    mem[8'h10] = 16'hBEEF;
    mem[8'h01] = 16'h1111;
    mem[8'h02] = 16'h2222;
    for (int i = 0; i < W; i++) pipe[i] = 16'hDEAD;

    // Reset, then one idle cycle.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_mem_en", {31'h0, mem_en}, 32'h0);
    chk("reset_rdata", {16'h0, rdata}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_rdata_valid", {31'h0, rdata_valid}, 32'h0);
    @(posedge clk); #1;

    // Single load: 3 stall cycles, data on release; rdata holds afterwards.
    lw(8'h10, 16'hBEEF, 3);
    alu();
    chk("rdata_hold", {16'h0, rdata}, 32'h0000BEEF);

    // Posted store followed by two ALU ops, then read it back.
    sw(8'h20, 16'h1234);
    alu();
    alu();
    lw(8'h20, 16'h1234, 3);

    // Store immediately followed by a load: 2 cycles drain wait + 3 own.
    sw(8'h30, 16'hABCD);
    lw(8'h30, 16'hABCD, 5);

    // Back-to-back loads.
    lw(8'h01, 16'h1111, 3);
    lw(8'h02, 16'h2222, 3);

    // Reset during RD_BUSY.
    op_q.push_back({1'b0, 8'h10, 16'h0});
    mem_read = 1'b1; addr = 8'h10;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdbusy_stall", {31'h0, stall}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_stall", {31'h0, stall}, 32'h0);
    chk("midreset_mem_en", {31'h0, mem_en}, 32'h0);
    chk("midreset_rdata_valid", {31'h0, rdata_valid}, 32'h0);
    chk("midreset_rdata", {16'h0, rdata}, 32'h0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rv_seen = 0; stall_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rdata_valid) rv_seen++;
      if (stall) stall_seen++;
    end
    chk("post_reset_rdata_valid", rv_seen, 0);
    chk("post_reset_stall", stall_seen, 0);
    @(posedge clk); #1;

    // Simultaneous read+write: treated as a write, err sticks.
    op_q.push_back({1'b1, 8'h40, 16'h5555});
    instr(1'b1, 1'b1, 8'h40, 16'h5555, 0, "both");
    chk("err_set", {31'h0, err}, 32'h1);
    alu();
    alu();
    chk("err_sticky", {31'h0, err}, 32'h1);
    lw(8'h40, 16'h5555, 3);
    chk("err_sticky_after_lw", {31'h0, err}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("err_cleared_by_reset", {31'h0, err}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    repeat (3) @(posedge clk);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("op_q_drained", op_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
